frv_interrupt_ctrl: RTL

Machine-mode interrupt sequencer for the frv core.
- Samples external, timer and software interrupt sources and applies mie/mstatus.MIE masking and fixed priority.
- Presents one committed interrupt request to the writeback stage, which raises it as a trap through cf_req/cf_ack.
- Blocks further requests until the handler retires MRET.
- Sits beside the CSR file; drives mip and the writeback stage's interrupt-trap input.

---
 rtl/frv_interrupt_ctrl_pkg.sv | 39 +++
 rtl/frv_sync2.sv | 28 ++
 rtl/frv_interrupt_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/frv_interrupt_ctrl_pkg.sv
// Shared constants and types for the frv machine-mode interrupt sequencer:
// trap cause codes, mip/mie bit positions, FSM encoding and the priority
// encoder used to pick the cause of a new request.
package frv_interrupt_ctrl_pkg;

  // Machine-mode interrupt cause codes presented to the writeback stage.
  localparam logic [5:0] TRAP_INT_MEI = 6'd11;
  localparam logic [5:0] TRAP_INT_MSI = 6'd3;
  localparam logic [5:0] TRAP_INT_MTI = 6'd7;

  // Bit positions inside mip / mie.
  localparam int P_MEI = 2;
  localparam int P_MTI = 1;
  localparam int P_MSI = 0;

  // Interrupt sequencer states.
  typedef enum logic [1:0] {
    INTC_IDLE   = 2'd0,
    INTC_REQ    = 2'd1,
    INTC_ACTIVE = 2'd2
  } intc_state_t;

  // Fixed priority MEI > MSI > MTI. Returns 0 when nothing is eligible,
  // which never reaches the output because a request needs |elig.
  function automatic logic [5:0] intc_cause(input logic [2:0] elig);
    logic [5:0] cause;
    if (elig[P_MEI]) begin
      cause = TRAP_INT_MEI;
    end else if (elig[P_MSI]) begin
      cause = TRAP_INT_MSI;
    end else if (elig[P_MTI]) begin
      cause = TRAP_INT_MTI;
    end else begin
      cause = 6'd0;
    end
    return cause;
  endfunction

endpackage

// File: rtl/frv_sync2.sv
// Generic two-flop synchroniser for asynchronous level inputs.
// Both stages clear to 0 on synchronous active-low reset.
module frv_sync2 #(
  parameter int W = 1
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/frv_interrupt_ctrl.sv
// Machine-mode interrupt sequencer for the frv core. Samples the external,
// timer and software sources into mip, masks them with mie/mstatus.MIE,
// commits one request to writeback and holds off further requests until
// the handler retires MRET. Also measures request-to-acknowledge latency.
module frv_interrupt_ctrl
  import frv_interrupt_ctrl_pkg::*;
#(
  parameter int LAT_W    = 16,
  parameter bit SYNC_EXT = 1'b1
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             int_ext,
  input  logic             int_tim,
  input  logic             int_sw,
  input  logic             csr_mstatus_mie,
  input  logic [2:0]       csr_mie,
  output logic [2:0]       csr_mip,
  output logic             int_req,
  output logic [5:0]       int_cause,
  input  logic             int_ack,
  input  logic             mret_done,
  output logic             int_active,
  output logic [LAT_W-1:0] int_lat
);

  logic             ext_s;
  logic [2:0]       mip_q;
  logic [2:0]       elig_s;
  logic             fire_s;
  logic [LAT_W-1:0] cnt_inc_s;

  intc_state_t      state_q;
  logic             req_q;
  logic [5:0]       cause_q;
  logic             active_q;
  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] lat_q;

  generate
    if (SYNC_EXT) begin : g_ext_sync
      frv_sync2 #(.W(1)) u_sync_ext (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .d_i      (int_ext),
        .q_o      (ext_s)
      );
    end else begin : g_ext_raw
      assign ext_s = int_ext;
    end
  endgenerate

  // Pending bits track the sources every cycle, regardless of enables/state.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      mip_q <= 3'b000;
    end else begin
      mip_q <= {ext_s, int_tim, int_sw};
    end
  end

  assign elig_s    = mip_q & csr_mie;
  assign fire_s    = csr_mstatus_mie && (|elig_s);
  assign cnt_inc_s = (&cnt_q) ? cnt_q : (cnt_q + LAT_W'(1));

  // Request sequencer: the cause is frozen once committed, ack beats mret
  // in REQ, and stray ack/mret pulses outside their state are ignored.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q  <= INTC_IDLE;
      req_q    <= 1'b0;
      cause_q  <= 6'd0;
      active_q <= 1'b0;
      cnt_q    <= '0;
      lat_q    <= '0;
    end else begin
      case (state_q)
        INTC_IDLE: begin
          if (fire_s) begin
            state_q <= INTC_REQ;
            req_q   <= 1'b1;
            cause_q <= intc_cause(elig_s);
            cnt_q   <= '0;
          end
        end
        INTC_REQ: begin
          if (int_ack) begin
            state_q  <= INTC_ACTIVE;
            req_q    <= 1'b0;
            active_q <= 1'b1;
            lat_q    <= cnt_inc_s;
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end
        INTC_ACTIVE: begin
          if (mret_done) begin
            state_q  <= INTC_IDLE;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= INTC_IDLE;
          req_q    <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign csr_mip    = mip_q;
  assign int_req    = req_q;
  assign int_cause  = cause_q;
  assign int_active = active_q;
  assign int_lat    = lat_q;

endmodule
